commit_checker: RTL and testbench
=================================

COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 Parameter DEPTH, default 4, sets expected-record FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 256, sets the cycle-count limit for the watchdog (see REQ-030).
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 exp_valid  in  1  expected commit record offered.
REQ-006 exp_ready  out  1  FIFO can accept a record.
REQ-007 exp_flags  in  3  {halt, mem_wr, reg_wr} of the expected record.
REQ-008 exp_pc  in  16  expected PC.
REQ-009 exp_reg  in  3 / exp_reg_data  in  16  expected write register and value.
REQ-010 exp_mem_addr  in  16 / exp_mem_data  in  16  expected store address and value.
REQ-011 cm_valid  in  1  the DUT commits one instruction this cycle.
REQ-012 cm_flags, cm_pc, cm_reg, cm_reg_data, cm_mem_addr, cm_mem_data  in  same widths as the exp_* fields  observed commit record.
REQ-013 done  out  1  halt record matched.
REQ-014 error  out  1  mismatch detected.
REQ-015 err_code  out  3  cause of error.
REQ-016 err_inum  out  16  index of the failing commit.
REQ-017 inst_count  out  16  matched commits.

Function
REQ-018 States: RUN, DONE, ERROR; reset state is RUN.
REQ-019 Push: exp_valid && exp_ready writes the record at the tail; exp_ready = ~full in RUN, 0 in DONE/ERROR.
REQ-020 Pop: in RUN, cm_valid pops the head and compares it with cm_* in the same cycle; results are registered, so done/error assert on the following cycle.
REQ-021 Push and pop in the same cycle update the FIFO correctly; a full FIFO with a pop still reports exp_ready=0 that cycle.
REQ-022 cm_valid with the FIFO empty sets err_code=1 (underflow); a same-cycle push is not bypassed to the comparator.
REQ-023 Compare priority: pc mismatch->2; flags mismatch->3; reg_wr set and (reg or reg_data) mismatch->4; mem_wr set and (mem_addr or mem_data) mismatch->5; the lowest code wins.
REQ-024 reg_* fields are ignored when reg_wr=0; mem_* fields are ignored when mem_wr=0.
REQ-025 Any mismatch: go to ERROR, latch err_code, and set err_inum=inst_count (0-based index of the failing commit).
REQ-026 Full match: inst_count increments (saturating at 16'hFFFF); a match with halt=1 goes to DONE.
REQ-027 DONE/ERROR are sticky until rst; cm_valid and exp_valid are ignored there; all outputs are frozen.
REQ-028 FIFO pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.

Reset
REQ-029 rst in any state, including mid-compare, clears FIFO and inst_count, returns to RUN, and drives done=0, error=0, err_code=0, err_inum=0, inst_count=0. exp_ready=1 in the cycle after rst deasserts.

Configuration
REQ-030 Macro COMMIT_CHECKER_WATCHDOG_EN, when defined: in RUN, a counter counts cycles without cm_valid and resets on cm_valid. Reaching TIMEOUT sets error, err_code=6, and err_inum=inst_count.
REQ-031 Without COMMIT_CHECKER_WATCHDOG_EN, no counter is built and err_code 6 never occurs.

Verification
REQ-032 Push 3 matching records (reg write r1=0x0005 at pc 0x0000, store 0x0010<-0x0005 at 0x0002, halt at 0x0004), then commit each -> inst_count=3; done=1 the cycle after the halt; error=0.
REQ-033 Expected pc 0x0002, committed pc 0x0004 with cm_valid as the first commit -> error=1, err_code=2, err_inum=0; later commits leave all outputs unchanged.
REQ-034 Record with reg_wr=0 but differing reg_data -> match; with reg_wr=1 and reg_data 0x1234 vs 0x1235 -> err_code=4.
REQ-035 Push DEPTH records without commits -> exp_ready=0. Commit and push in the same cycle -> the record is accepted after the pop, and the wrap-around order is preserved across 3*DEPTH records.
REQ-036 cm_valid with an empty FIFO -> err_code=1. Assert rst the next cycle -> all outputs 0, state RUN.
REQ-037 With COMMIT_CHECKER_WATCHDOG_EN and TIMEOUT=8, 8 idle cycles in RUN -> error=1, err_code=6; without the macro -> no error.

Source files
------------

// File: rtl/commit_checker.sv
// Commit checker: matches observed commits against a FIFO of expected records; the watchdog is built only with `define COMMIT_CHECKER_WATCHDOG_EN.
// Latency: compare results are registered one cycle after cm_valid. Backpressure: exp_ready drops when full or once DONE/ERROR is reached.
module commit_checker #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [2:0]  exp_flags,
    input  logic [15:0] exp_pc,
    input  logic [2:0]  exp_reg,
    input  logic [15:0] exp_reg_data,
    input  logic [15:0] exp_mem_addr,
    input  logic [15:0] exp_mem_data,
    input  logic        cm_valid,
    input  logic [2:0]  cm_flags,
    input  logic [15:0] cm_pc,
    input  logic [2:0]  cm_reg,
    input  logic [15:0] cm_reg_data,
    input  logic [15:0] cm_mem_addr,
    input  logic [15:0] cm_mem_data,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [15:0] err_inum,
    output logic [15:0] inst_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam int F_REG  = 0;
    localparam int F_MEM  = 1;
    localparam int F_HALT = 2;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_UNDER = 3'd1;
    localparam logic [2:0] E_PC    = 3'd2;
    localparam logic [2:0] E_FLAGS = 3'd3;
    localparam logic [2:0] E_REG   = 3'd4;
    localparam logic [2:0] E_MEM   = 3'd5;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("commit_checker: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("commit_checker: TIMEOUT must be at least 1");
    end

    typedef struct packed {
        logic [2:0]  flags;
        logic [15:0] pc;
        logic [2:0]  dst;
        logic [15:0] dst_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
    } rec_t;

    typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_ERROR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [15:0]   err_inum_q, err_inum_d;
    logic [15:0]   inst_count_q, inst_count_d;
    rec_t          fifo_q [DEPTH];

    rec_t       exp_rec;
    rec_t       head;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic [2:0] cmp_code;
    logic       wd_expire;

    assign exp_rec    = '{flags: exp_flags, pc: exp_pc, dst: exp_reg, dst_data: exp_reg_data,
                          mem_addr: exp_mem_addr, mem_data: exp_mem_data};
    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign exp_ready  = (state_q == ST_RUN) && !fifo_full;
    assign push       = exp_valid && exp_ready;
    // A commit against an empty FIFO never sees a same-cycle push.
    assign pop        = (state_q == ST_RUN) && cm_valid && !fifo_empty;

    always_comb begin
        cmp_code = E_NONE;
        if (cm_pc != head.pc) begin
            cmp_code = E_PC;
        end else if (cm_flags != head.flags) begin
            cmp_code = E_FLAGS;
        end else if (head.flags[F_REG] && (cm_reg != head.dst || cm_reg_data != head.dst_data)) begin
            cmp_code = E_REG;
        end else if (head.flags[F_MEM] && (cm_mem_addr != head.mem_addr || cm_mem_data != head.mem_data)) begin
            cmp_code = E_MEM;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        err_inum_d   = err_inum_q;
        inst_count_d = inst_count_q;
        if (state_q == ST_RUN) begin
            if (cm_valid) begin
                if (fifo_empty) begin
                    state_d    = ST_ERROR;
                    err_code_d = E_UNDER;
                    err_inum_d = inst_count_q;
                end else if (cmp_code != E_NONE) begin
                    state_d    = ST_ERROR;
                    err_code_d = cmp_code;
                    err_inum_d = inst_count_q;
                end else begin
                    inst_count_d = (inst_count_q == 16'hFFFF) ? inst_count_q : inst_count_q + 16'd1;
                    if (head.flags[F_HALT]) begin
                        state_d = ST_DONE;
                    end
                end
            end else if (wd_expire) begin
                state_d    = ST_ERROR;
                err_code_d = 3'd6;
                err_inum_d = inst_count_q;
            end
        end
    end

`ifdef COMMIT_CHECKER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_cnt_q, wd_cnt_d;

    // Fires on the TIMEOUT-th consecutive idle cycle in RUN.
    assign wd_expire = (wd_cnt_q == WW'(TIMEOUT - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_RUN) begin
            if (cm_valid) begin
                wd_cnt_d = '0;
            end else if (!wd_expire) begin
                wd_cnt_d = wd_cnt_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= exp_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_code_q   <= '0;
            err_inum_q   <= '0;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_code_q   <= err_code_d;
            err_inum_q   <= err_inum_d;
            inst_count_q <= inst_count_d;
        end
    end

    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);
    assign err_code   = err_code_q;
    assign err_inum   = err_inum_q;
    assign inst_count = inst_count_q;
endmodule

// File: tb/tb_commit_checker.sv
// Self-checking bench for commit_checker: per-scenario tasks with a scoreboard of expected output snapshots.
`timescale 1ns/1ps
module tb_commit_checker;
    localparam int DEPTH      = 4;
    localparam int TB_TIMEOUT = 8;

    typedef struct packed {
        logic [2:0]  flags;
        logic [15:0] pc;
        logic [2:0]  dst;
        logic [15:0] dst_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
    } rec_t;

    typedef struct packed {
        logic        done;
        logic        error;
        logic [2:0]  code;
        logic [15:0] inum;
        logic [15:0] cnt;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        exp_valid;
    logic        exp_ready;
    logic        cm_valid;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [15:0] err_inum;
    logic [15:0] inst_count;
    rec_t        exp_r;
    rec_t        cm_r;

    int   n_cmp;
    int   n_err;
    obs_t sb_q[$];

    commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .exp_valid    (exp_valid),
        .exp_ready    (exp_ready),
        .exp_flags    (exp_r.flags),
        .exp_pc       (exp_r.pc),
        .exp_reg      (exp_r.dst),
        .exp_reg_data (exp_r.dst_data),
        .exp_mem_addr (exp_r.mem_addr),
        .exp_mem_data (exp_r.mem_data),
        .cm_valid     (cm_valid),
        .cm_flags     (cm_r.flags),
        .cm_pc        (cm_r.pc),
        .cm_reg       (cm_r.dst),
        .cm_reg_data  (cm_r.dst_data),
        .cm_mem_addr  (cm_r.mem_addr),
        .cm_mem_data  (cm_r.mem_data),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .err_inum     (err_inum),
        .inst_count   (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [2:0] f, input logic [15:0] pc, input logic [2:0] d,
                                input logic [15:0] dd, input logic [15:0] ma, input logic [15:0] md);
        rec_t r;
        r = '{flags: f, pc: pc, dst: d, dst_data: dd, mem_addr: ma, mem_data: md};
        return r;
    endfunction

    function automatic obs_t ob(input logic dn, input logic er, input logic [2:0] c,
                                input logic [15:0] i, input logic [15:0] n);
        obs_t o;
        o = '{done: dn, error: er, code: c, inum: i, cnt: n};
        return o;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o = '{done: done, error: error, code: err_code, inum: err_inum, cnt: inst_count};
        return o;
    endfunction

    function automatic rec_t wrec(input int i);
        return mk(3'b001, 16'(i * 2), 3'(i), 16'(i * 257 + 1), 16'h0, 16'h0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        exp_valid = 1'b0;
        cm_valid  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_rec(input rec_t r);
        exp_r     = r;
        exp_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic commit_rec(input rec_t r);
        cm_r     = r;
        cm_valid = 1'b1;
        tick();
        cm_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (cur() !== obs_t'('0)) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", cur(), obs_t'('0));
        end
        n_cmp++;
        if (exp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", exp_ready);
        end
    endtask

    task automatic test_basic();
        rec_t r[3];
        obs_t e;
        r[0] = mk(3'b001, 16'h0000, 3'd1, 16'h0005, 16'h0000, 16'h0000);
        r[1] = mk(3'b010, 16'h0002, 3'd0, 16'h0000, 16'h0010, 16'h0005);
        r[2] = mk(3'b100, 16'h0004, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        do_reset();
        for (int i = 0; i < 3; i++) push_rec(r[i]);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(ob(i == 2, 1'b0, 3'd0, 16'd0, 16'(i + 1)));
            commit_rec(r[i]);
            e = sb_q.pop_front();
            n_cmp++;
            if (cur() !== e) begin
                n_err++;
                $display("FAIL basic_commit%0d: got %h want %h", i, cur(), e);
            end
        end
        sb_q.push_back(ob(1'b1, 1'b0, 3'd0, 16'd0, 16'd3));
        commit_rec(mk(3'b000, 16'h0099, 3'd0, 16'h0, 16'h0, 16'h0));
        e = sb_q.pop_front();
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL done_sticky: got %h want %h", cur(), e);
        end
        n_cmp++;
        if (exp_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_ready: got %b want 0", exp_ready);
        end
    endtask

    task automatic test_pc_mismatch();
        obs_t e;
        do_reset();
        push_rec(mk(3'b000, 16'h0002, 3'd0, 16'h0, 16'h0, 16'h0));
        push_rec(mk(3'b000, 16'h0006, 3'd0, 16'h0, 16'h0, 16'h0));
        sb_q.push_back(ob(1'b0, 1'b1, 3'd2, 16'd0, 16'd0));
        commit_rec(mk(3'b000, 16'h0004, 3'd0, 16'h0, 16'h0, 16'h0));
        e = sb_q.pop_front();
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL pc_mismatch: got %h want %h", cur(), e);
        end
        sb_q.push_back(ob(1'b0, 1'b1, 3'd2, 16'd0, 16'd0));
        commit_rec(mk(3'b000, 16'h0006, 3'd0, 16'h0, 16'h0, 16'h0));
        e = sb_q.pop_front();
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL error_sticky: got %h want %h", cur(), e);
        end
        n_cmp++;
        if (exp_ready !== 1'b0) begin
            n_err++;
            $display("FAIL error_ready: got %b want 0", exp_ready);
        end
    endtask

    task automatic test_priority();
        rec_t       ce[7];
        rec_t       cc[7];
        logic [2:0] code[7];
        rec_t       pre;
        obs_t       e;
        pre = mk(3'b000, 16'h00F0, 3'd0, 16'h0, 16'h0, 16'h0);
        ce[0] = mk(3'b001, 16'h0010, 3'd1, 16'h1234, 16'h0, 16'h0);
        cc[0] = mk(3'b010, 16'h0012, 3'd1, 16'h9999, 16'h0, 16'h0);    code[0] = 3'd2;
        ce[1] = mk(3'b001, 16'h0010, 3'd1, 16'h1234, 16'h0, 16'h0);
        cc[1] = mk(3'b011, 16'h0010, 3'd1, 16'h1235, 16'h0, 16'h0);    code[1] = 3'd3;
        ce[2] = mk(3'b001, 16'h0020, 3'd2, 16'h1234, 16'h0, 16'h0);
        cc[2] = mk(3'b001, 16'h0020, 3'd2, 16'h1235, 16'h0, 16'h0);    code[2] = 3'd4;
        ce[3] = mk(3'b011, 16'h0030, 3'd3, 16'h0055, 16'h0040, 16'h0066);
        cc[3] = mk(3'b011, 16'h0030, 3'd4, 16'h0055, 16'h0040, 16'h0067); code[3] = 3'd4;
        ce[4] = mk(3'b010, 16'h0030, 3'd0, 16'h0000, 16'h0040, 16'h0066);
        cc[4] = mk(3'b010, 16'h0030, 3'd0, 16'h0000, 16'h0041, 16'h0066); code[4] = 3'd5;
        ce[5] = mk(3'b000, 16'h0050, 3'd1, 16'h1111, 16'h0040, 16'h0066);
        cc[5] = mk(3'b000, 16'h0050, 3'd2, 16'h2222, 16'h0099, 16'h0077); code[5] = 3'd0;
        ce[6] = mk(3'b001, 16'h0050, 3'd3, 16'hAAAA, 16'h0040, 16'h0066);
        cc[6] = mk(3'b001, 16'h0050, 3'd3, 16'hAAAA, 16'h0041, 16'h0067); code[6] = 3'd0;
        for (int k = 0; k < 7; k++) begin
            do_reset();
            push_rec(pre);
            push_rec(ce[k]);
            sb_q.push_back(ob(1'b0, 1'b0, 3'd0, 16'd0, 16'd1));
            commit_rec(pre);
            e = sb_q.pop_front();
            n_cmp++;
            if (cur() !== e) begin
                n_err++;
                $display("FAIL prio_pre%0d: got %h want %h", k, cur(), e);
            end
            if (code[k] == 3'd0) sb_q.push_back(ob(1'b0, 1'b0, 3'd0, 16'd0, 16'd2));
            else                 sb_q.push_back(ob(1'b0, 1'b1, code[k], 16'd1, 16'd1));
            commit_rec(cc[k]);
            e = sb_q.pop_front();
            n_cmp++;
            if (cur() !== e) begin
                n_err++;
                $display("FAIL prio_case%0d: got %h want %h", k, cur(), e);
            end
        end
    endtask

    task automatic test_full_wrap();
        int   pushed;
        int   committed;
        int   it;
        logic rdy;
        obs_t e;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_rec(wrec(i));
        n_cmp++;
        if (exp_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got %b want 0", exp_ready);
        end
        pushed    = DEPTH;
        committed = 0;
        it        = 0;
        while (committed < 3 * DEPTH && it < 64) begin
            cm_valid  = (committed < pushed);
            cm_r      = wrec(committed);
            exp_valid = (pushed < 3 * DEPTH);
            exp_r     = wrec(pushed);
            rdy       = exp_ready;
            if (it == 0) begin
                n_cmp++;
                if (rdy !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_pop_ready: got %b want 0", rdy);
                end
            end else if (it == 1) begin
                n_cmp++;
                if (rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL after_pop_ready: got %b want 1", rdy);
                end
            end
            if (cm_valid) sb_q.push_back(ob(1'b0, 1'b0, 3'd0, 16'd0, 16'(committed + 1)));
            tick();
            if (exp_valid && rdy) pushed++;
            if (cm_valid) begin
                committed++;
                e = sb_q.pop_front();
                n_cmp++;
                if (cur() !== e) begin
                    n_err++;
                    $display("FAIL wrap_commit%0d: got %h want %h", committed, cur(), e);
                end
            end
            it++;
        end
        cm_valid  = 1'b0;
        exp_valid = 1'b0;
        n_cmp++;
        if (committed != 3 * DEPTH) begin
            n_err++;
            $display("FAIL wrap_budget: got %0d commits want %0d", committed, 3 * DEPTH);
        end
    endtask

    task automatic test_underflow();
        obs_t e;
        do_reset();
        cm_r      = mk(3'b000, 16'h0000, 3'd0, 16'h0, 16'h0, 16'h0);
        exp_r     = cm_r;
        cm_valid  = 1'b1;
        exp_valid = 1'b1;
        sb_q.push_back(ob(1'b0, 1'b1, 3'd1, 16'd0, 16'd0));
        tick();
        cm_valid  = 1'b0;
        exp_valid = 1'b0;
        e = sb_q.pop_front();
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL underflow: got %h want %h", cur(), e);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (cur() !== obs_t'('0)) begin
            n_err++;
            $display("FAIL underflow_rst: got %h want %h", cur(), obs_t'('0));
        end
        rst = 1'b0;
        n_cmp++;
        if (exp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release_ready: got %b want 1", exp_ready);
        end
        push_rec(mk(3'b000, 16'h0008, 3'd0, 16'h0, 16'h0, 16'h0));
        sb_q.push_back(ob(1'b0, 1'b0, 3'd0, 16'd0, 16'd1));
        commit_rec(mk(3'b000, 16'h0008, 3'd0, 16'h0, 16'h0, 16'h0));
        e = sb_q.pop_front();
        n_cmp++;
        if (cur() !== e) begin
            n_err++;
            $display("FAIL rst_back_to_run: got %h want %h", cur(), e);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
`ifdef COMMIT_CHECKER_WATCHDOG_EN
        repeat (TB_TIMEOUT - 1) tick();
        n_cmp++;
        if (error !== 1'b0) begin
            n_err++;
            $display("FAIL wd_early: got %b want 0", error);
        end
        tick();
        n_cmp++;
        if (cur() !== ob(1'b0, 1'b1, 3'd6, 16'd0, 16'd0)) begin
            n_err++;
            $display("FAIL wd_fire: got %h want %h", cur(), ob(1'b0, 1'b1, 3'd6, 16'd0, 16'd0));
        end
`else
        repeat (3 * TB_TIMEOUT) tick();
        n_cmp++;
        if (cur() !== obs_t'('0)) begin
            n_err++;
            $display("FAIL no_watchdog: got %h want %h", cur(), obs_t'('0));
        end
`endif
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        exp_valid = 1'b0;
        cm_valid  = 1'b0;
        exp_r     = '0;
        cm_r      = '0;
        test_reset();
        test_basic();
        test_pc_mismatch();
        test_priority();
        test_full_wrap();
        test_underflow();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "time budget exhausted");
    end
endmodule
